// File: rtl/commit_sequencer_pkg.sv
// Shared constants and the entry control record for the commit sequencer.
package commit_sequencer_pkg;

  localparam int DEF_ROB_WIDTH = 4;   // tag width; buffer depth is 2**DEF_ROB_WIDTH
  localparam int DEF_REG_WIDTH = 32;  // result data width
  localparam int REG_ID_WIDTH  = 5;   // architectural register id width

  // Control half of a buffer entry; the result value is kept in a separate array.
  typedef struct packed {
    logic                    busy;  // entry allocated and not yet retired
    logic                    done;  // result has been captured
    logic [REG_ID_WIDTH-1:0] rd;    // destination register id
  } rob_ctrl_t;

  // Bit offsets of the fields inside a packed rob_ctrl_t.
  localparam int CTRL_RD_LSB  = 0;
  localparam int CTRL_DONE_BIT = REG_ID_WIDTH;
  localparam int CTRL_BUSY_BIT = REG_ID_WIDTH + 1;
  localparam int CTRL_WIDTH    = REG_ID_WIDTH + 2;

  // x0 is hardwired to zero, so a retiring entry targeting it never writes back.
  function automatic logic writes_back(input logic [REG_ID_WIDTH-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/commit_sequencer_rob_entry_bank.sv
// Entry storage for the commit sequencer: allocate and complete write ports,
// a head read port with retire-clear, and a whole-buffer flush clear.
module rob_entry_bank
  import commit_sequencer_pkg::*;
#(
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,      // already qualified with rdy
  input  logic                    alloc_we_i,
  input  logic [ROB_WIDTH-1:0]    alloc_idx_i,
  input  logic [REG_ID_WIDTH-1:0] alloc_rd_i,
  input  logic                    cmpl_we_i,
  input  logic [ROB_WIDTH-1:0]    cmpl_idx_i,
  input  logic [REG_WIDTH-1:0]    cmpl_value_i,
  output logic                    cmpl_busy_o,  // busy bit of the entry a completion targets
  input  logic                    retire_i,
  input  logic [ROB_WIDTH-1:0]    head_idx_i,
  output rob_ctrl_t               head_ctrl_o,
  output logic [REG_WIDTH-1:0]    head_value_o
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  rob_ctrl_t            ctrl_q  [DEPTH];
  logic [REG_WIDTH-1:0] value_q [DEPTH];

  // Control bits: flush wipes everything; otherwise retire, allocate and complete update their entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctrl_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i].busy <= 1'b0;
        ctrl_q[i].done <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments, so later writes in this block win on the same entry
      // and every read above sees the pre-edge state, which is what the hardware does.
      if (retire_i) begin
        ctrl_q[head_idx_i].busy <= 1'b0;
        ctrl_q[head_idx_i].done <= 1'b0;
      end
      if (alloc_we_i) begin
        ctrl_q[alloc_idx_i] <= '{busy: 1'b1, done: 1'b0, rd: alloc_rd_i};
      end
      if (cmpl_we_i) begin
        ctrl_q[cmpl_idx_i].done <= 1'b1;
      end
    end
  end

  // Result values: written on completion only.
  // NOTE: the value array is deliberately not reset; an entry's value is only read once
  // its done bit is set, and done is reset, so resetting this RAM would buy nothing.
  always_ff @(posedge clk) begin
    if (cmpl_we_i && !flush_i) begin
      value_q[cmpl_idx_i] <= cmpl_value_i;
    end
  end

  assign cmpl_busy_o  = ctrl_q[cmpl_idx_i].busy;
  assign head_ctrl_o  = ctrl_q[head_idx_i];
  assign head_value_o = value_q[head_idx_i];

endmodule

// File: rtl/commit_sequencer.sv
// In-order commit controller: allocates tags at issue, captures completions and
// retires the head entry at most once per cycle towards the register file.
module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    alloc_valid,
  input  logic [REG_ID_WIDTH-1:0] alloc_rd,
  output logic                    alloc_ready,
  output logic [ROB_WIDTH-1:0]    alloc_tag,
  input  logic                    cmpl_valid,
  input  logic [ROB_WIDTH-1:0]    cmpl_tag,
  input  logic [REG_WIDTH-1:0]    cmpl_value,
  input  logic                    flush_in,
  output logic                    rob_commit_signal,
  output logic [ROB_WIDTH-1:0]    commit_rd_tag,
  output logic [REG_WIDTH-1:0]    commit_rd_value,
  output logic [REG_ID_WIDTH-1:0] commit_rd_id,
  output logic [ROB_WIDTH:0]      count,
  output logic                    empty
);

  localparam int                 DEPTH      = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);
  localparam logic [ROB_WIDTH:0] CNT_ONE    = (ROB_WIDTH + 1)'(1);
  localparam logic [ROB_WIDTH-1:0] PTR_ONE  = ROB_WIDTH'(1);

  logic [ROB_WIDTH-1:0]    head_q, head_d;
  logic [ROB_WIDTH-1:0]    tail_q, tail_d;
  logic [ROB_WIDTH:0]      count_q, count_d;

  logic                    commit_valid_q, commit_valid_d;
  logic [ROB_WIDTH-1:0]    commit_tag_q, commit_tag_d;
  logic [REG_WIDTH-1:0]    commit_value_q, commit_value_d;
  logic [REG_ID_WIDTH-1:0] commit_id_q, commit_id_d;

  rob_ctrl_t               head_ctrl;
  logic [REG_WIDTH-1:0]    head_value;
  logic                    cmpl_busy;

  logic                    flush_fire;
  logic                    alloc_fire;
  logic                    cmpl_fire;
  logic                    commit_fire;

  // Full is judged on registered count only, so a same-cycle retire never unblocks issue.
  assign alloc_ready = (count_q != FULL_COUNT);
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);

  // Flush outranks everything; nothing fires while paused.
  assign flush_fire  = rdy_in & flush_in;
  assign alloc_fire  = rdy_in & ~flush_in & alloc_valid & alloc_ready;
  assign cmpl_fire   = rdy_in & ~flush_in & cmpl_valid & cmpl_busy;
  assign commit_fire = rdy_in & ~flush_in & head_ctrl.busy & head_ctrl.done;

  rob_entry_bank #(
    .ROB_WIDTH (ROB_WIDTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_bank (
    .clk          (clk_in),
    .rst_n        (rst_n_in),
    .flush_i      (flush_fire),
    .alloc_we_i   (alloc_fire),
    .alloc_idx_i  (tail_q),
    .alloc_rd_i   (alloc_rd),
    .cmpl_we_i    (cmpl_fire),
    .cmpl_idx_i   (cmpl_tag),
    .cmpl_value_i (cmpl_value),
    .cmpl_busy_o  (cmpl_busy),
    .retire_i     (commit_fire),
    .head_idx_i   (head_q),
    .head_ctrl_o  (head_ctrl),
    .head_value_o (head_value)
  );

  // Pointer and occupancy next state; count moves only when exactly one of allocate/commit fires.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_fire) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire)  tail_d = tail_q + PTR_ONE;
      if (commit_fire) head_d = head_q + PTR_ONE;
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Commit output next state: strobe is rebuilt every unpaused cycle, data holds unless an entry retires.
  always_comb begin
    commit_valid_d = commit_valid_q;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;
    commit_id_d    = commit_id_q;
    if (rdy_in) begin
      commit_valid_d = 1'b0;
      if (commit_fire) begin
        commit_valid_d = writes_back(head_ctrl.rd);
        commit_tag_d   = head_q;
        commit_value_d = head_value;
        commit_id_d    = head_ctrl.rd;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Commit output registers towards the register file.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      commit_id_q    <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
      commit_id_q    <= commit_id_d;
    end
  end

  assign rob_commit_signal = commit_valid_q;
  assign commit_rd_tag     = commit_tag_q;
  assign commit_rd_value   = commit_value_q;
  assign commit_rd_id      = commit_id_q;

endmodule

// File: tb/tb_commit_sequencer.sv
// Directed bench for commit_sequencer: reset, single commit, out-of-order
// completion, full/wrap, x0 and stale completion, flush, pause, async reset.
module tb_commit_sequencer;

  localparam int RW = 4;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          rdy_in;
  logic          alloc_valid;
  logic [4:0]    alloc_rd;
  logic          alloc_ready;
  logic [RW-1:0] alloc_tag;
  logic          cmpl_valid;
  logic [RW-1:0] cmpl_tag;
  logic [DW-1:0] cmpl_value;
  logic          flush_in;
  logic          rob_commit_signal;
  logic [RW-1:0] commit_rd_tag;
  logic [DW-1:0] commit_rd_value;
  logic [4:0]    commit_rd_id;
  logic [RW:0]   count;
  logic          empty;

  int n_checks = 0;
  int n_errors = 0;

  commit_sequencer #(.ROB_WIDTH(RW), .REG_WIDTH(DW)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .rdy_in            (rdy_in),
    .alloc_valid       (alloc_valid),
    .alloc_rd          (alloc_rd),
    .alloc_ready       (alloc_ready),
    .alloc_tag         (alloc_tag),
    .cmpl_valid        (cmpl_valid),
    .cmpl_tag          (cmpl_tag),
    .cmpl_value        (cmpl_value),
    .flush_in          (flush_in),
    .rob_commit_signal (rob_commit_signal),
    .commit_rd_tag     (commit_rd_tag),
    .commit_rd_value   (commit_rd_value),
    .commit_rd_id      (commit_rd_id),
    .count             (count),
    .empty             (empty)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    cmpl_valid  = 1'b0;
    cmpl_tag    = '0;
    cmpl_value  = '0;
    flush_in    = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_cmpl(input logic [RW-1:0] tag, input logic [DW-1:0] val);
    cmpl_valid = 1'b1;
    cmpl_tag   = tag;
    cmpl_value = val;
    tick();
    cmpl_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    idle_inputs();
    #12;
    // ---- reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_strobe", 64'(rob_commit_signal), 64'd0);
    check("rst_commit_data", {27'(commit_rd_tag), 32'(commit_rd_value), 5'(commit_rd_id)}, 64'd0);
    rst_n_in = 1'b1;
    tick();

    // ---- single instruction
    do_alloc(5'd5);
    check("single_count_after_alloc", 64'(count), 64'd1);
    check("single_alloc_tag", 64'(alloc_tag), 64'd1);
    do_cmpl(4'd0, 32'hDEADBEEF);
    check("single_no_strobe_at_cmpl", 64'(rob_commit_signal), 64'd0);
    tick();
    check("single_strobe", 64'(rob_commit_signal), 64'd1);
    check("single_tag", 64'(commit_rd_tag), 64'd0);
    check("single_value", 64'(commit_rd_value), 64'hDEADBEEF);
    check("single_rd", 64'(commit_rd_id), 64'd5);
    check("single_empty", 64'(empty), 64'd1);
    tick();
    check("single_strobe_drop", 64'(rob_commit_signal), 64'd0);
    check("single_value_hold", 64'(commit_rd_value), 64'hDEADBEEF);

    // ---- out-of-order completion, in-order commit
    do_flush();
    check("ooo_flush_tag", 64'(alloc_tag), 64'd0);
    do_alloc(5'd1);
    do_alloc(5'd2);
    do_alloc(5'd3);
    check("ooo_count", 64'(count), 64'd3);
    do_cmpl(4'd2, 32'h0000_0022);
    check("ooo_no_strobe_c2", 64'(rob_commit_signal), 64'd0);
    do_cmpl(4'd1, 32'h0000_0011);
    check("ooo_no_strobe_c1", 64'(rob_commit_signal), 64'd0);
    do_cmpl(4'd0, 32'h0000_0010);
    check("ooo_no_strobe_c0", 64'(rob_commit_signal), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ooo_strobe_%0d", i), 64'(rob_commit_signal), 64'd1);
      check($sformatf("ooo_tag_%0d", i), 64'(commit_rd_tag), 64'(i));
      check($sformatf("ooo_rd_%0d", i), 64'(commit_rd_id), 64'(i + 1));
    end
    check("ooo_value_last", 64'(commit_rd_value), 64'h22);
    tick();
    check("ooo_strobe_end", 64'(rob_commit_signal), 64'd0);
    check("ooo_empty", 64'(empty), 64'd1);

    // ---- full and wrap
    do_flush();
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alloc_rd = 5'(i + 1);
      tick();
    end
    check("full_count", 64'(count), 64'd16);
    check("full_ready", 64'(alloc_ready), 64'd0);
    check("full_tag_wrapped", 64'(alloc_tag), 64'd0);
    tick();  // alloc_valid still high while full
    check("full_ignored_count", 64'(count), 64'd16);
    check("full_ignored_tag", 64'(alloc_tag), 64'd0);
    alloc_valid = 1'b0;
    do_cmpl(4'd0, 32'h0000_00A0);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    tick();  // retire edge: alloc still blocked by registered full count
    check("full_retire_strobe", 64'(rob_commit_signal), 64'd1);
    check("full_retire_count", 64'(count), 64'd15);
    check("full_ready_again", 64'(alloc_ready), 64'd1);
    check("full_next_tag", 64'(alloc_tag), 64'd0);
    tick();  // grant wrapped tag 0
    alloc_valid = 1'b0;
    check("wrap_count", 64'(count), 64'd16);
    check("wrap_tag_after", 64'(alloc_tag), 64'd1);
    check("wrap_ready", 64'(alloc_ready), 64'd0);

    // ---- x0 and stale completion
    do_flush();
    check("flush_count", 64'(count), 64'd0);
    do_alloc(5'd0);
    do_cmpl(4'd0, 32'h0000_0055);
    tick();
    check("x0_no_strobe", 64'(rob_commit_signal), 64'd0);
    check("x0_retired", 64'(count), 64'd0);
    check("x0_empty", 64'(empty), 64'd1);
    do_cmpl(4'd1, 32'h0000_0099);  // entry 1 is free
    check("stale_count", 64'(count), 64'd0);
    tick();
    check("stale_no_strobe", 64'(rob_commit_signal), 64'd0);
    check("stale_tag", 64'(alloc_tag), 64'd1);

    // ---- flush concurrent with allocate, complete and commit
    do_alloc(5'd7);                // tag 1
    do_cmpl(4'd1, 32'h0000_0077);  // head now done
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    cmpl_valid  = 1'b1;
    cmpl_tag    = 4'd1;
    cmpl_value  = 32'h0000_0088;
    flush_in    = 1'b1;
    tick();
    idle_inputs();
    check("flush_mix_count", 64'(count), 64'd0);
    check("flush_mix_strobe", 64'(rob_commit_signal), 64'd0);
    check("flush_mix_tag", 64'(alloc_tag), 64'd0);
    check("flush_mix_value_hold", 64'(commit_rd_value), 64'h55);
    tick();
    check("flush_mix_strobe_later", 64'(rob_commit_signal), 64'd0);

    // ---- pause with a done head
    do_alloc(5'd4);                // tag 0
    do_cmpl(4'd0, 32'h0000_1234);
    rdy_in      = 1'b0;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pause_strobe_%0d", i), 64'(rob_commit_signal), 64'd0);
      check($sformatf("pause_count_%0d", i), 64'(count), 64'd1);
    end
    alloc_valid = 1'b0;
    rdy_in      = 1'b1;
    tick();
    check("pause_commit_strobe", 64'(rob_commit_signal), 64'd1);
    check("pause_commit_value", 64'(commit_rd_value), 64'h1234);
    check("pause_commit_rd", 64'(commit_rd_id), 64'd4);
    check("pause_commit_count", 64'(count), 64'd0);
    rdy_in = 1'b0;
    tick();
    check("pause_strobe_held", 64'(rob_commit_signal), 64'd1);
    rdy_in = 1'b1;
    tick();
    check("pause_strobe_release", 64'(rob_commit_signal), 64'd0);

    // ---- asynchronous reset mid-operation
    do_alloc(5'd3);                // tag 1
    do_alloc(5'd6);                // tag 2
    do_cmpl(4'd1, 32'h0000_0333);
    tick();
    check("arst_pre_strobe", 64'(rob_commit_signal), 64'd1);
    check("arst_pre_count", 64'(count), 64'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_tag", 64'(alloc_tag), 64'd0);
    check("arst_strobe", 64'(rob_commit_signal), 64'd0);
    check("arst_value", 64'(commit_rd_value), 64'd0);
    #3;
    rst_n_in = 1'b1;
    tick();
    tick();
    check("arst_after_strobe", 64'(rob_commit_signal), 64'd0);
    check("arst_after_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/commit_sequencer.md
# commit_sequencer

In-order commit controller for the register file's commit port. It allocates ROB tags at issue and records each instruction's destination register. It captures completion results and retires the head entry once per cycle, driving `rob_commit_signal`, `commit_rd_tag` and `commit_rd_value` into `register_file`. A circular buffer of `2**ROB_WIDTH` entries with head/tail pointers and an occupancy counter provides the in-order sequencing and back-pressure to issue.

## Interface
- `ROB_WIDTH`, 4, tag width; buffer depth is `2**ROB_WIDTH`.
- `REG_WIDTH`, 32, data width.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: pause; when low, all state holds.
- `alloc_valid` in 1: issue requests a tag.
- `alloc_rd` in 5: destination register id of the issuing instruction.
- `alloc_ready` out 1: buffer not full.
- `alloc_tag` out ROB_WIDTH: tag granted; equals the tail pointer.
- `cmpl_valid` in 1: result broadcast.
- `cmpl_tag` in ROB_WIDTH: completing entry.
- `cmpl_value` in REG_WIDTH: result value.
- `flush_in` in 1: discard all entries (mispredict).
- `rob_commit_signal` out 1: registered commit strobe to `register_file`.
- `commit_rd_tag` out ROB_WIDTH: tag of the committing entry.
- `commit_rd_value` out REG_WIDTH: value of the committing entry.
- `commit_rd_id` out 5: destination register of the committing entry (debug/trace).
- `count` out ROB_WIDTH+1: occupancy.
- `empty` out 1: `count == 0`.

## Operation
- **Entry fields:** `busy`, `done`, `rd[4:0]`, `value`.
- **Allocate:** fires when `rdy_in & alloc_valid & alloc_ready`.
  - Writes `entry[tail]` = {busy=1, done=0, rd=alloc_rd}.
  - Increments `tail` modulo depth.
  - `alloc_ready = (count != 2**ROB_WIDTH)`, derived from registered count only; a same-cycle commit does not unblock a full buffer.
- **Complete:** fires when `rdy_in & cmpl_valid & entry[cmpl_tag].busy`.
  - Sets `done=1` and stores `value`.
  - Completion to a non-busy entry is ignored.
- **Commit:** fires when `rdy_in & entry[head].busy & entry[head].done`.
  - Clears `busy` and increments `head`.
  - Next cycle: `rob_commit_signal=1` with that entry's tag, value and rd.
  - Otherwise `rob_commit_signal=0` next cycle; data outputs hold their last values.
  - Entries with `rd==0` retire normally but `rob_commit_signal` stays 0, so x0 is never written.
  - At most one commit per cycle.
- **Counter:** `count` increments on allocate only, decrements on commit only, and is unchanged when both fire. Pointer wrap is modulo `2**ROB_WIDTH`.
- **Simultaneous allocate and complete** to the same index cannot occur (completion targets busy entries only).
- **Flush:** sampled when `rdy_in` is high.
  - Clears every `busy`, sets `head=tail=0` and `count=0`.
  - `rob_commit_signal=0` next cycle.
  - Overrides allocate, complete and commit in the same cycle.
- **`rdy_in` low:** no state or output register changes, including `rob_commit_signal`. `register_file` gates commit with `rdy_in`, so a held strobe is not double-applied.

## Timing
- **Reset (async on `rst_n_in` low):**
  - `head=tail=0`, `count=0`, all `busy=0`.
  - Outputs: `alloc_tag=0`, `alloc_ready=1`, `empty=1`, `rob_commit_signal=0`, `commit_rd_tag=0`, `commit_rd_value=0`, `commit_rd_id=0`.
- **Reset mid-operation:** all in-flight entries are lost and the strobe drops immediately, without waiting for a clock edge.
- **Combinational outputs:** `alloc_tag` and `alloc_ready` follow the pointers and count; `empty` follows `count`.
- **Latency:** a completion sampled at edge k into the head entry gives `rob_commit_signal` high after edge k+1.
- **Back-to-back commits:** the strobe stays high on consecutive cycles when consecutive head entries are done.
- **Allocate to commit:** minimum 2 edges (allocate at edge k, complete at the same edge is not allowed, so complete at edge k+1 or later).

## Structure
- Shared package/header: `ROB_WIDTH` default, `REG_WIDTH`, `REG_ID_WIDTH=5`, and an entry record/field-offset constants.
- One sub-module, `rob_entry_bank`: the entry storage array, with write ports for allocate and complete, a head read port and a flush-clear.
- Pointers, counter and commit output registers live in `commit_sequencer`.

## Test plan
- **Reset:** hold `rst_n_in` low mid-run → `count=0`, `alloc_tag=0`, `rob_commit_signal=0` asynchronously.
- **Single instruction:** allocate rd=5 (tag 0), complete tag 0 with 0xDEADBEEF → one strobe with tag 0, value 0xDEADBEEF, rd 5; `empty=1` after.
- **Out-of-order completion:** allocate tags 0,1,2; complete in order 2,1,0 → commits strictly in tag order 0,1,2 on three consecutive cycles after tag 0 completes.
- **Full/wrap:** with ROB_WIDTH=4, 16 allocations → `alloc_ready=0`. Further `alloc_valid` is ignored. Retiring one entry re-raises `alloc_ready`; the next tag granted is 0 (wrap).
- **x0 and stale completion:** allocate rd=0, complete it → head advances, no strobe. A `cmpl_tag` pointing at a free entry causes no change.
- **Flush and pause:** flush concurrent with allocate, complete and commit → `count=0`, no strobe next cycle. Dropping `rdy_in` for 3 cycles with a done head → state frozen, commit happens after `rdy_in` returns.
